ram_1p_arbiter: RTL and testbench

// Shares one single-port 32-bit data SRAM (1-cycle registered read, byte-write enables)

---
 rtl/ram_1p_arbiter.sv | 119 +++++++++++
 tb/tb_ram_1p_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1p_arbiter.sv
// ram_1p_arbiter: two LSU-protocol hosts (req/gnt/rvalid) share one single-port
// 32-bit SRAM with a 1-cycle registered read.
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   hN_req/we/be/addr/wdata_i     host N request (N = 0 core data, 1 loader/debug)
//   hN_gnt_o                      combinational accept
//   hN_rvalid/err/rdata_o         response, exactly one cycle after gnt
//   ram_valid/we/addr/wdata_o     SRAM command, ram_rdata_i one cycle later
// Round-robin between hosts. Accesses outside [BASE, BASE+4*SIZE) are granted
// but never reach the SRAM; they answer with err=1 and zero data.
module ram_1p_arbiter #(
  parameter logic [31:0] BASE = 32'h0010_0000,
  parameter int unsigned SIZE = 16384,
  parameter int unsigned AW   = 14
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          h0_req_i,
  output logic          h0_gnt_o,
  input  logic          h0_we_i,
  input  logic [3:0]    h0_be_i,
  input  logic [31:0]   h0_addr_i,
  input  logic [31:0]   h0_wdata_i,
  output logic          h0_rvalid_o,
  output logic          h0_err_o,
  output logic [31:0]   h0_rdata_o,
  input  logic          h1_req_i,
  output logic          h1_gnt_o,
  input  logic          h1_we_i,
  input  logic [3:0]    h1_be_i,
  input  logic [31:0]   h1_addr_i,
  input  logic [31:0]   h1_wdata_i,
  output logic          h1_rvalid_o,
  output logic          h1_err_o,
  output logic [31:0]   h1_rdata_o,
  output logic          ram_valid_o,
  output logic [3:0]    ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [31:0]   ram_wdata_o,
  input  logic [31:0]   ram_rdata_i
);

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } host_req_t;

  // Window bounds widened to 33 bits so BASE+4*SIZE cannot wrap.
  localparam logic [32:0] LO = {1'b0, BASE};
  localparam logic [32:0] HI = LO + (33'(SIZE) << 2);

  host_req_t [1:0] hreq;
  host_req_t       sel;
  logic            gnt_any, gnt_host, in_range;
  logic [31:0]     offs;
  logic            unused_offs;

  logic prio_q, prio_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_host_q, rsp_host_d;
  logic rsp_err_q, rsp_err_d;

  assign hreq[0] = '{we: h0_we_i, be: h0_be_i, addr: h0_addr_i, wdata: h0_wdata_i};
  assign hreq[1] = '{we: h1_we_i, be: h1_be_i, addr: h1_addr_i, wdata: h1_wdata_i};

  // Grant depends on req and prio_q only, so junk on idle payloads or the
  // response state can never disturb it.
  assign gnt_any  = rst_ni & (h0_req_i | h1_req_i);
  assign gnt_host = (h0_req_i & h1_req_i) ? prio_q : h1_req_i;
  assign h0_gnt_o = gnt_any & ~gnt_host;
  assign h1_gnt_o = gnt_any &  gnt_host;

  assign sel      = hreq[gnt_host];
  assign in_range = ({1'b0, sel.addr} >= LO) && ({1'b0, sel.addr} < HI);
  assign offs     = sel.addr - BASE;

  assign ram_valid_o = gnt_any & in_range;
  assign ram_we_o    = ram_valid_o ? (sel.be & {4{sel.we}}) : 4'b0;
  assign ram_addr_o  = offs[AW+1:2];
  assign ram_wdata_o = sel.wdata;

  // Byte-offset bits and bits above the window are irrelevant once in_range holds.
  assign unused_offs = ^{offs[31:AW+2], offs[1:0]};

  always_comb begin
    prio_d      = prio_q;
    rsp_valid_d = gnt_any;
    rsp_host_d  = rsp_host_q;
    rsp_err_d   = rsp_err_q;
    if (gnt_any) begin
      prio_d     = ~gnt_host;  // winner drops to lowest priority
      rsp_host_d = gnt_host;
      rsp_err_d  = ~in_range;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_host_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_host_q  <= rsp_host_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign h0_rvalid_o = rsp_valid_q & ~rsp_host_q;
  assign h1_rvalid_o = rsp_valid_q &  rsp_host_q;
  assign h0_err_o    = h0_rvalid_o & rsp_err_q;
  assign h1_err_o    = h1_rvalid_o & rsp_err_q;
  assign h0_rdata_o  = (h0_rvalid_o & ~rsp_err_q) ? ram_rdata_i : 32'h0;
  assign h1_rdata_o  = (h1_rvalid_o & ~rsp_err_q) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_1p_arbiter.sv
module tb_ram_1p_arbiter;
  localparam logic [31:0] B = 32'h0010_0000;
  localparam int SIZE = 16384;
  localparam int AW   = 14;

  logic clk = 1'b0, rst_n = 1'b0;
  logic h0_req = 0, h0_we = 0, h1_req = 0, h1_we = 0;
  logic [3:0] h0_be = 0, h1_be = 0;
  logic [31:0] h0_addr = 0, h0_wdata = 0, h1_addr = 0, h1_wdata = 0;
  logic h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, h0_err, h1_err;
  logic [31:0] h0_rdata, h1_rdata, ram_wdata, ram_rdata;
  logic ram_valid;
  logic [3:0] ram_we;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  ram_1p_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .h0_req_i(h0_req), .h0_gnt_o(h0_gnt), .h0_we_i(h0_we), .h0_be_i(h0_be),
    .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata), .h0_rvalid_o(h0_rvalid),
    .h0_err_o(h0_err), .h0_rdata_o(h0_rdata),
    .h1_req_i(h1_req), .h1_gnt_o(h1_gnt), .h1_we_i(h1_we), .h1_be_i(h1_be),
    .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata), .h1_rvalid_o(h1_rvalid),
    .h1_err_o(h1_err), .h1_rdata_o(h1_rdata),
    .ram_valid_o(ram_valid), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // SRAM device: registered read of old contents, byte writes, side load port.
  bit [31:0] mem [SIZE];
  logic ld_en = 0;
  int ld_a = 0;
  logic [31:0] ld_d = 0;
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (ram_valid) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // Reference model: expected memory image, tie-break owner, pending response.
  bit [31:0] shadow [SIZE];
  int tie_win = 0, last_g = -1, pend_host = 0;
  bit pend_v = 0, pend_err = 0, pend_dchk = 0;
  logic [31:0] pend_data = 0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'hA5A5_0000;
      1: return 32'h1122_3344;
      2: return 32'hDEAD_BEEF;
      default: return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0101);
    endcase
  endfunction

  // Called at negedge with inputs driven; checks this cycle, advances model, ends at next negedge.
  task automatic step();
    int g, idx;
    bit ir;
    longint a;
    logic [31:0] ad, wd;
    logic we;
    logic [3:0] be;
    #1;
    chk("h0_rvalid", 32'(h0_rvalid), 32'(pend_v && pend_host == 0));
    chk("h1_rvalid", 32'(h1_rvalid), 32'(pend_v && pend_host == 1));
    chk("h0_err", 32'(h0_err), 32'(pend_v && pend_host == 0 && pend_err));
    chk("h1_err", 32'(h1_err), 32'(pend_v && pend_host == 1 && pend_err));
    if (pend_v && (pend_dchk || pend_err))
      chk("rsp_rdata", (pend_host == 1) ? h1_rdata : h0_rdata, pend_err ? 32'h0 : pend_data);
    g = -1;
    if (h0_req && h1_req) g = tie_win;
    else if (h0_req) g = 0;
    else if (h1_req) g = 1;
    chk("h0_gnt", 32'(h0_gnt), 32'(g == 0));
    chk("h1_gnt", 32'(h1_gnt), 32'(g == 1));
    if (g >= 0) begin
      ad = g ? h1_addr : h0_addr;  we = g ? h1_we : h0_we;
      be = g ? h1_be : h0_be;      wd = g ? h1_wdata : h0_wdata;
      a = {32'h0, ad};
      ir = (a >= longint'(B)) && (a < longint'(B) + 4 * SIZE);
      chk("ram_valid", 32'(ram_valid), 32'(ir));
      pend_v = 1; pend_host = g; pend_err = !ir; pend_dchk = ir && !we;
      if (ir) begin
        idx = int'((a - longint'(B)) >> 2);
        chk("ram_addr", 32'(ram_addr), 32'(idx));
        chk("ram_we", 32'(ram_we), 32'(we ? be : 4'b0));
        if (we) chk("ram_wdata", ram_wdata, wd);
        pend_data = shadow[idx];
        for (int b = 0; b < 4; b++)
          if (we && be[b]) shadow[idx][8*b +: 8] = wd[8*b +: 8];
      end else chk("ram_we", 32'(ram_we), 32'h0);
      tie_win = 1 - g;
    end else begin
      chk("ram_valid", 32'(ram_valid), 32'h0);
      chk("ram_we", 32'(ram_we), 32'h0);
      pend_v = 0;
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic gen(output logic req, output logic we, output logic [3:0] be,
                     output logic [31:0] addr, output logic [31:0] wd);
    int r;
    req = ($urandom_range(0, 9) < 6);
    we = 1'($urandom); be = 4'($urandom); wd = $urandom;
    r = $urandom_range(0, 9);
    if (!req) addr = $urandom;  // idle payload is junk
    else if (r < 7) addr = B + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
    else if (r == 7) addr = B - 32'(4 * $urandom_range(1, 4));
    else if (r == 8) addr = B + 32'h1_0000 + 32'(4 * $urandom_range(0, 3));
    else addr = $urandom;
  endtask

  typedef struct {
    logic r0, r1, we0, we1;
    logic [3:0] be0, be1;
    logic [31:0] a0, a1;
    logic g0, g1, rv;
    logic [3:0] rwe;
    logic [13:0] ra;
  } vec_t;
  vec_t tbl [10];

  initial begin
    tbl[0] = '{1,1,0,0,4'hF,4'hF, B+32'h10, B+32'h20,        1,0,1,4'h0,14'd4};
    tbl[1] = '{1,1,1,0,4'hF,4'hF, B+32'h10, B+32'h20,        0,1,1,4'h0,14'd8};
    tbl[2] = '{1,0,1,0,4'hF,4'hF, B+32'h10, B+32'h20,        1,0,1,4'hF,14'd4};
    tbl[3] = '{1,0,0,0,4'hF,4'hF, B-32'h4,  B,               1,0,0,4'h0,14'd0};
    tbl[4] = '{0,1,0,1,4'hF,4'h3, B,        B+32'hFFFC,      0,1,1,4'h3,14'd16383};
    tbl[5] = '{0,0,0,0,4'hF,4'hF, B,        B,               0,0,0,4'h0,14'd0};
    tbl[6] = '{0,1,0,0,4'hF,4'hF, B,        B+32'h1_0000,    0,1,0,4'h0,14'd0};
    tbl[7] = '{1,1,0,0,4'hF,4'hF, B,        B+32'h8,         1,0,1,4'h0,14'd0};
    tbl[8] = '{0,1,0,0,4'hF,4'hF, B,        B+32'h8,         0,1,1,4'h0,14'd2};
    tbl[9] = '{1,0,0,0,4'hF,4'hF, 32'hFFFF_FFFC, B,          1,0,0,4'h0,14'd0};

    // Preload while in reset; requests held high must not be granted.
    h0_req = 1; h1_req = 1;
    for (int i = 0; i < 64; i++) begin
      ld_en = 1; ld_a = i; ld_d = init_word(i); shadow[i] = init_word(i);
      @(negedge clk);
    end
    ld_en = 0;
    #1;
    chk("rst h0_gnt", 32'(h0_gnt), 32'h0);
    chk("rst h1_gnt", 32'(h1_gnt), 32'h0);
    chk("rst ram_valid", 32'(ram_valid), 32'h0);
    chk("rst ram_we", 32'(ram_we), 32'h0);
    chk("rst rvalid", 32'({h0_rvalid, h1_rvalid}), 32'h0);
    chk("rst rdata", h0_rdata | h1_rdata, 32'h0);
    h0_req = 0; h1_req = 0;
    @(negedge clk);
    rst_n = 1;

    // Table vectors from reset.
    for (int i = 0; i < 10; i++) begin
      h0_req = tbl[i].r0; h1_req = tbl[i].r1; h0_we = tbl[i].we0; h1_we = tbl[i].we1;
      h0_be = tbl[i].be0; h1_be = tbl[i].be1; h0_addr = tbl[i].a0; h1_addr = tbl[i].a1;
      h0_wdata = 32'h1000_0000 + 32'(i); h1_wdata = 32'h2000_0000 + 32'(i);
      #1;
      chk($sformatf("tbl%0d g0", i), 32'(h0_gnt), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d g1", i), 32'(h1_gnt), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d rv", i), 32'(ram_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d rwe", i), 32'(ram_we), 32'(tbl[i].rwe));
      if (tbl[i].rv) chk($sformatf("tbl%0d ra", i), 32'(ram_addr), 32'(tbl[i].ra));
      step();
    end
    h0_req = 0; h1_req = 0; step();

    // Read of preloaded word2.
    h0_req = 1; h0_we = 0; h0_addr = B + 32'h8; step();
    h0_req = 0; #1;
    chk("rd2 h0_rdata", h0_rdata, 32'hDEAD_BEEF);
    chk("rd2 h1_rvalid", 32'(h1_rvalid), 32'h0);
    step();

    // Partial write then read back.
    h1_req = 1; h1_we = 1; h1_be = 4'b0011; h1_addr = B + 32'h4; h1_wdata = 32'hAABB_CCDD; step();
    h1_we = 0; step();
    h1_req = 0; #1;
    chk("bew h1_rdata", h1_rdata, 32'h1122_CCDD);
    step();

    // Reset while a response is pending: it must vanish.
    h1_req = 1; h1_we = 0; h1_addr = B + 32'hC; step();
    rst_n = 0; h0_req = 1; h0_we = 0; h0_addr = B; h1_addr = B + 32'h4; #1;
    chk("mid-rst h1_rvalid", 32'(h1_rvalid), 32'h0);
    chk("mid-rst gnt", 32'({h0_gnt, h1_gnt}), 32'h0);
    pend_v = 0; tie_win = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;

    // Both requesting every cycle: strict alternation starting at h0.
    for (int k = 0; k < 4; k++) begin
      h0_addr = B + 32'(8 * k); h1_addr = B + 32'(8 * k + 4); #1;
      chk($sformatf("rr%0d h0_gnt", k), 32'(h0_gnt), 32'(k % 2 == 0));
      chk($sformatf("rr%0d ram_addr", k), 32'(ram_addr), 32'(2 * k + (k % 2)));
      step();
    end
    h0_req = 0; h1_req = 0; step();

    // Out-of-range accesses, then word0 still intact.
    h0_req = 1; h0_we = 1; h0_be = 4'hF; h0_addr = B + 32'h1_0000; h0_wdata = 32'hFFFF_FFFF; #1;
    chk("oor gnt", 32'(h0_gnt), 32'h1);
    chk("oor ram_valid", 32'(ram_valid), 32'h0);
    chk("oor ram_we", 32'(ram_we), 32'h0);
    step();
    h0_addr = B - 32'h4; #1;
    chk("oor h0_err", 32'(h0_err), 32'h1);
    chk("oor h0_rdata", h0_rdata, 32'h0);
    step();
    h0_we = 0; h0_addr = B; step();
    h0_req = 0; #1;
    chk("word0 kept", h0_rdata, 32'hA5A5_0000);
    step();

    // Back-to-back reads.
    for (int k = 0; k < 3; k++) begin
      h0_req = 1; h0_we = 0; h0_addr = B + 32'(4 * k); step();
    end
    h0_req = 0; step();

    // Random traffic; a request is held until granted.
    for (int c = 0; c < 400; c++) begin
      if (!(h0_req && last_g != 0)) gen(h0_req, h0_we, h0_be, h0_addr, h0_wdata);
      if (!(h1_req && last_g != 1)) gen(h1_req, h1_we, h1_be, h1_addr, h1_wdata);
      step();
    end
    h0_req = 0; h1_req = 0; step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
